// File: rtl/deflection_port_alloc.sv
`default_nettype none
// ============================================================================
// Module   : deflection_port_alloc
// Brief    : Oldest-first output port allocator for a bufferless deflection
//            router; losers deflect, injection fills a leftover network port.
// Revision : 1.0
// ============================================================================
module deflection_port_alloc #(
    parameter int WIDTH_AGE = 8,
    parameter int WIDTH_CNT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             in_valid,
    input  logic [19:0]            in_prod,
    input  logic [4*WIDTH_AGE-1:0] in_age,
    input  logic                   inj_valid,
    input  logic [4:0]             inj_prod,
    output logic                   inj_ack,
    output logic [4:0]             out_valid,
    output logic [14:0]            out_src,
    output logic [5*WIDTH_AGE-1:0] out_age,
    output logic [3:0]             out_deflect,
    output logic [WIDTH_CNT-1:0]   deflect_cnt
);

    localparam logic [2:0] c_src_inj = 3'd4;

    function automatic logic [2:0] f_lowest(input logic [4:0] v);
        f_lowest = 3'd0;
        for (int b = 4; b >= 0; b--) begin
            if (v[b]) f_lowest = 3'(b);
        end
    endfunction

    function automatic logic [WIDTH_AGE-1:0] f_age_inc(input logic [WIDTH_AGE-1:0] a);
        f_age_inc = (a == {WIDTH_AGE{1'b1}}) ? a : a + 1'b1;
    endfunction

    logic [1:0]             r_rr_q,          w_rr_d;
    logic                   r_inj_ack_q,     w_inj_ack_d;
    logic [4:0]             r_out_valid_q,   w_out_valid_d;
    logic [14:0]            r_out_src_q,     w_out_src_d;
    logic [5*WIDTH_AGE-1:0] r_out_age_q,     w_out_age_d;
    logic [3:0]             r_out_deflect_q, w_out_deflect_d;
    logic [WIDTH_CNT-1:0]   r_cnt_q,         w_cnt_d;

    logic [WIDTH_AGE-1:0] w_age  [4];
    logic [1:0]           w_rot  [4];
    logic [1:0]           w_rank [4];
    logic [4:0]           w_free;
    logic [4:0]           w_cand;
    logic [3:0]           w_inj_cand;
    logic [2:0]           w_port;
    logic [1:0]           w_sel;
    logic                 w_hit;
    logic [2:0]           w_ndefl;
    logic [WIDTH_CNT:0]   w_sum;
    logic                 w_unused;

    // Bit 4 of the injection vector is meaningless: injection never ejects.
    assign w_unused = inj_prod[4];

    always_comb begin
        w_free          = 5'b11111;
        w_cand          = '0;
        w_inj_cand      = '0;
        w_port          = '0;
        w_sel           = '0;
        w_hit           = 1'b0;
        w_out_valid_d   = '0;
        w_out_src_d     = '0;
        w_out_age_d     = '0;
        w_out_deflect_d = '0;
        w_inj_ack_d     = 1'b0;

        for (int i = 0; i < 4; i++) begin
            w_age[i] = in_age[WIDTH_AGE*i +: WIDTH_AGE];
            w_rot[i] = 2'(i) - r_rr_q;
        end

        // Rank = number of valid inputs that beat this one (older, or tied
        // and earlier in rotating order); ranks of valid inputs are unique.
        for (int i = 0; i < 4; i++) begin
            w_rank[i] = 2'd0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && in_valid[j] &&
                    ((w_age[j] > w_age[i]) ||
                     (w_age[j] == w_age[i] && w_rot[j] < w_rot[i]))) begin
                    w_rank[i] = w_rank[i] + 2'd1;
                end
            end
        end

        for (int pos = 0; pos < 4; pos++) begin
            w_hit = 1'b0;
            w_sel = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && w_rank[i] == 2'(pos)) begin
                    w_hit = 1'b1;
                    w_sel = 2'(i);
                end
            end
            if (w_hit) begin
                w_cand = in_prod[5*w_sel +: 5] & w_free;
                if (|w_cand) begin
                    w_port = f_lowest(w_cand);
                end else begin
                    w_port = f_lowest({1'b0, w_free[3:0]});
                    w_out_deflect_d[w_sel] = 1'b1;
                end
                w_free[w_port]                              = 1'b0;
                w_out_valid_d[w_port]                       = 1'b1;
                w_out_src_d[3*w_port +: 3]                  = {1'b0, w_sel};
                w_out_age_d[WIDTH_AGE*w_port +: WIDTH_AGE] = f_age_inc(w_age[w_sel]);
            end
        end

        w_inj_cand = inj_prod[3:0] & w_free[3:0];
        if (inj_valid && (|w_free[3:0])) begin
            w_port = (|w_inj_cand) ? f_lowest({1'b0, w_inj_cand})
                                   : f_lowest({1'b0, w_free[3:0]});
            w_out_valid_d[w_port]      = 1'b1;
            w_out_src_d[3*w_port +: 3] = c_src_inj;
            w_inj_ack_d                = 1'b1;
        end

        w_ndefl = {2'b00, w_out_deflect_d[0]} + {2'b00, w_out_deflect_d[1]} +
                  {2'b00, w_out_deflect_d[2]} + {2'b00, w_out_deflect_d[3]};
        w_sum   = {1'b0, r_cnt_q} + (WIDTH_CNT+1)'(w_ndefl);
        w_cnt_d = w_sum[WIDTH_CNT] ? {WIDTH_CNT{1'b1}} : w_sum[WIDTH_CNT-1:0];
        w_rr_d  = (|in_valid) ? r_rr_q + 2'd1 : r_rr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_q          <= '0;
            r_inj_ack_q     <= 1'b0;
            r_out_valid_q   <= '0;
            r_out_src_q     <= '0;
            r_out_age_q     <= '0;
            r_out_deflect_q <= '0;
            r_cnt_q         <= '0;
        end else begin
            r_rr_q          <= w_rr_d;
            r_inj_ack_q     <= w_inj_ack_d;
            r_out_valid_q   <= w_out_valid_d;
            r_out_src_q     <= w_out_src_d;
            r_out_age_q     <= w_out_age_d;
            r_out_deflect_q <= w_out_deflect_d;
            r_cnt_q         <= w_cnt_d;
        end
    end

    assign inj_ack     = r_inj_ack_q;
    assign out_valid   = r_out_valid_q;
    assign out_src     = r_out_src_q;
    assign out_age     = r_out_age_q;
    assign out_deflect = r_out_deflect_q;
    assign deflect_cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_deflection_port_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_deflection_port_alloc
// Brief    : Directed and random checks of deflection_port_alloc against a
//            sort-then-allocate reference model.
// Revision : 1.0
// ============================================================================
module tb_deflection_port_alloc;

    localparam int WA = 8;
    localparam int WC = 6;
    localparam int AGE_MAX = (1 << WA) - 1;
    localparam int CNT_MAX = (1 << WC) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    in_valid;
    logic [19:0]   in_prod;
    logic [4*WA-1:0] in_age;
    logic          inj_valid;
    logic [4:0]    inj_prod;
    logic          inj_ack;
    logic [4:0]    out_valid;
    logic [14:0]   out_src;
    logic [5*WA-1:0] out_age;
    logic [3:0]    out_deflect;
    logic [WC-1:0] deflect_cnt;

    always #5 clk = ~clk;

    deflection_port_alloc #(.WIDTH_AGE(WA), .WIDTH_CNT(WC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_prod(in_prod),
        .in_age(in_age), .inj_valid(inj_valid), .inj_prod(inj_prod),
        .inj_ack(inj_ack), .out_valid(out_valid), .out_src(out_src),
        .out_age(out_age), .out_deflect(out_deflect), .deflect_cnt(deflect_cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    int m_rr = 0;
    int m_cnt = 0;
    logic [4:0]      e_valid;
    logic [14:0]     e_src;
    logic [5*WA-1:0] e_age;
    logic [3:0]      e_defl;
    logic            e_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int age_of(input int i);
        return int'(in_age[WA*i +: WA]);
    endfunction

    function automatic bit beats(input int a, input int b);
        if (age_of(a) != age_of(b)) return age_of(a) > age_of(b);
        return ((a - m_rr + 4) % 4) < ((b - m_rr + 4) % 4);
    endfunction

    // Sort valid flits into priority order, then hand out ports one by one.
    task automatic model();
        int rem[$];
        int ord[$];
        bit fr[5];
        int nd;
        int p;
        e_valid = '0; e_src = '0; e_age = '0; e_defl = '0; e_ack = 1'b0;
        if (reset) begin
            m_rr = 0;
            m_cnt = 0;
            return;
        end
        for (int i = 0; i < 4; i++) if (in_valid[i]) rem.push_back(i);
        while (rem.size() > 0) begin
            int b = 0;
            for (int k = 1; k < rem.size(); k++) if (beats(rem[k], rem[b])) b = k;
            ord.push_back(rem[b]);
            rem.delete(b);
        end
        for (int q = 0; q < 5; q++) fr[q] = 1'b1;
        nd = 0;
        foreach (ord[k]) begin
            int s = ord[k];
            int a = age_of(s);
            p = -1;
            for (int q = 0; q < 5; q++) if (p < 0 && in_prod[5*s+q] && fr[q]) p = q;
            if (p < 0) begin
                for (int q = 0; q < 4; q++) if (p < 0 && fr[q]) p = q;
                e_defl[s] = 1'b1;
                nd++;
            end
            fr[p] = 1'b0;
            e_valid[p] = 1'b1;
            e_src[3*p +: 3] = 3'(s);
            e_age[WA*p +: WA] = WA'((a >= AGE_MAX) ? AGE_MAX : a + 1);
        end
        if (inj_valid) begin
            p = -1;
            for (int q = 0; q < 4; q++) if (p < 0 && inj_prod[q] && fr[q]) p = q;
            for (int q = 0; q < 4; q++) if (p < 0 && fr[q]) p = q;
            if (p >= 0) begin
                e_valid[p] = 1'b1;
                e_src[3*p +: 3] = 3'd4;
                e_ack = 1'b1;
            end
        end
        m_cnt = (m_cnt + nd > CNT_MAX) ? CNT_MAX : m_cnt + nd;
        if (|in_valid) m_rr = (m_rr + 1) % 4;
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("out_src", 64'(out_src), 64'(e_src));
        chk("out_age", 64'(out_age), 64'(e_age));
        chk("out_deflect", 64'(out_deflect), 64'(e_defl));
        chk("inj_ack", 64'(inj_ack), 64'(e_ack));
        chk("deflect_cnt", 64'(deflect_cnt), 64'(m_cnt));
    endtask

    task automatic clr();
        in_valid = '0; in_prod = '0; in_age = '0; inj_valid = 1'b0; inj_prod = '0;
    endtask

    task automatic flit(input int i, input int age, input logic [4:0] prod);
        in_valid[i] = 1'b1;
        in_age[WA*i +: WA] = WA'(age);
        in_prod[5*i +: 5] = prod;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        step();
        step();
        chk("reset_cnt", 64'(deflect_cnt), 64'd0);
        reset = 1'b0;
        step();
        chk("idle_valid", 64'(out_valid), 64'd0);

        // Single flit W -> E
        clr(); flit(0, 5, 5'b00010);
        step();
        chk("single_valid", 64'(out_valid), 64'b00010);
        chk("single_age", 64'(out_age[WA +: WA]), 64'd6);
        chk("single_defl", 64'(out_deflect), 64'd0);

        // Contention: W age 9 wins E, N age 3 deflects to W
        clr(); flit(0, 9, 5'b00010); flit(3, 3, 5'b00010);
        step();
        chk("cont_srcE", 64'(out_src[5:3]), 64'd0);
        chk("cont_srcW", 64'(out_src[2:0]), 64'd3);
        chk("cont_defl", 64'(out_deflect), 64'b1000);

        // Equal ages, rr_ptr 0 then 1
        reset = 1'b1; step(); reset = 1'b0;
        clr(); flit(0, 4, 5'b00010); flit(1, 4, 5'b00010);
        step();
        chk("tie_rr0_srcE", 64'(out_src[5:3]), 64'd0);
        chk("tie_rr0_defl", 64'(out_deflect), 64'b0010);
        step();
        chk("tie_rr1_srcE", 64'(out_src[5:3]), 64'd1);
        chk("tie_rr1_defl", 64'(out_deflect), 64'b0001);

        // Double ejection plus saturated age
        clr(); flit(0, 2, 5'b10000); flit(1, 7, 5'b10000); flit(2, 255, 5'b00100);
        step();
        chk("eject_srcL", 64'(out_src[14:12]), 64'd1);
        chk("eject_defl", 64'(out_deflect), 64'b0001);
        chk("sat_age", 64'(out_age[2*WA +: WA]), 64'd255);

        // Injection blocked, then admitted
        clr(); for (int i = 0; i < 4; i++) flit(i, i, 5'b00001 << i);
        inj_valid = 1'b1; inj_prod = 5'b01000;
        step();
        chk("inj_full_ack", 64'(inj_ack), 64'd0);
        clr(); for (int i = 0; i < 3; i++) flit(i, 1, 5'b00001 << i);
        inj_valid = 1'b1; inj_prod = 5'b11000;
        step();
        chk("inj_ack", 64'(inj_ack), 64'd1);
        chk("inj_srcN", 64'(out_src[11:9]), 64'd4);
        chk("inj_ageN", 64'(out_age[3*WA +: WA]), 64'd0);

        // Saturate the deflection counter
        clr(); for (int i = 0; i < 4; i++) flit(i, 10, 5'b00000);
        for (int k = 0; k < 18; k++) step();
        chk("cnt_sat", 64'(deflect_cnt), 64'(CNT_MAX));

        // Reset mid-traffic
        reset = 1'b1;
        step();
        chk("midreset_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;

        for (int n = 0; n < 400; n++) begin
            clr();
            reset = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 4; i++) begin
                int sel = int'($urandom_range(0, 3));
                int age = (sel == 0) ? int'($urandom_range(0, 255)) :
                          (sel == 1) ? 255 : int'($urandom_range(0, 2));
                in_age[WA*i +: WA] = WA'(age);
                in_prod[5*i +: 5] = 5'($urandom_range(0, 31));
            end
            in_valid  = 4'($urandom_range(0, 15));
            inj_valid = 1'($urandom_range(0, 1));
            inj_prod  = 5'($urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
